// File: rtl/clock_phase_pkg.sv
// Shared definitions for the four-phase clock scheduler: FSM states,
// phase indices and the phase-length decode.
package clock_phase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] PH_IMEM = 2'd0;
  localparam logic [1:0] PH_PROC = 2'd1;
  localparam logic [1:0] PH_DMEM = 2'd2;
  localparam logic [1:0] PH_REG  = 2'd3;

  // Last sub-counter value of a phase, i.e. P-1 where P = 1 << sel.
  function automatic logic [2:0] p_last_index(input logic [1:0] sel);
    logic [3:0] len;
    len = 4'd1 << sel;
    return 3'(len - 4'd1);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Sub-counter plus phase index; flags the last clock of a phase and the
// last clock of a major cycle.
module phase_counter
  import clock_phase_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] p_sel,
  output logic [1:0] phase,
  output logic       last_tick,
  output logic       cycle_end
);

  logic [2:0] sub_q, sub_d;
  logic [1:0] phase_q, phase_d;

  assign last_tick = (sub_q == p_last_index(p_sel));
  assign cycle_end = last_tick && (phase_q == PH_REG);
  assign phase     = phase_q;

  always_comb begin
    sub_d   = sub_q;
    phase_d = phase_q;
    if (clear) begin
      sub_d   = 3'd0;
      phase_d = PH_IMEM;
    end else if (enable) begin
      if (last_tick) begin
        sub_d   = 3'd0;
        phase_d = phase_q + 2'd1;
      end else begin
        sub_d = sub_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sub_q   <= 3'd0;
      phase_q <= PH_IMEM;
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/clock_phase_scheduler.sv
// Four-phase major-cycle sequencer: start/stop/drain FSM, per-phase enable
// pulses and a count of completed major cycles.
module clock_phase_scheduler
  import clock_phase_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       div_sel,
  output logic             imem_en,
  output logic             proc_en,
  output logic             dmem_en,
  output logic             regfile_en,
  output logic [1:0]       phase,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  state_e           state_q, state_d;
  logic [1:0]       p_sel_q, p_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic       cnt_enable;
  logic       cnt_clear;
  logic [1:0] phase_w;
  logic       last_tick;
  logic       cycle_end;

  // The counter is held cleared throughout IDLE, so a start always begins at phase 0.
  assign cnt_clear  = (state_q == ST_IDLE);
  assign cnt_enable = !cnt_clear;

  phase_counter u_phase_counter (
    .clock     (clock),
    .reset     (reset),
    .enable    (cnt_enable),
    .clear     (cnt_clear),
    .p_sel     (p_sel_q),
    .phase     (phase_w),
    .last_tick (last_tick),
    .cycle_end (cycle_end)
  );

  always_comb begin
    state_d = state_q;
    p_sel_d = p_sel_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          p_sel_d = div_sel;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (cycle_end) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            p_sel_d = div_sel;
          end
        end else if (stop) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cycle_end) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      p_sel_q <= 2'd0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_sel_q <= p_sel_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Enables decode only flop outputs, so no input reaches them combinationally.
  assign running     = (state_q != ST_IDLE);
  assign imem_en     = running && last_tick && (phase_w == PH_IMEM);
  assign proc_en     = running && last_tick && (phase_w == PH_PROC);
  assign dmem_en     = running && last_tick && (phase_w == PH_DMEM);
  assign regfile_en  = running && last_tick && (phase_w == PH_REG);
  assign phase       = phase_w;
  assign done        = done_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_clock_phase_scheduler.sv
// Bench for clock_phase_scheduler: directed scenarios plus random traffic,
// checked against a position-in-major-cycle reference model.
module tb_clock_phase_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [1:0] div_sel;

  logic        imemA, procA, dmemA, regA, runA, doneA;
  logic [1:0]  phA;
  logic [15:0] cntA;
  logic        imemB, procB, dmemB, regB, runB, doneB;
  logic [1:0]  phB;
  logic [3:0]  cntB;

  int total = 0;
  int bad   = 0;
  string stepName = "init";

  bit mActive, mDrain, mDone;
  int mPos, mP, mCnt;

  int accEn, accReg, accDone, accRun;

  always #5 clock = ~clock;

  clock_phase_scheduler u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .div_sel     (div_sel),
    .imem_en     (imemA),
    .proc_en     (procA),
    .dmem_en     (dmemA),
    .regfile_en  (regA),
    .phase       (phA),
    .running     (runA),
    .done        (doneA),
    .cycle_count (cntA)
  );

  clock_phase_scheduler #(.CNT_W(4)) u_dut4 (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .div_sel     (div_sel),
    .imem_en     (imemB),
    .proc_en     (procB),
    .dmem_en     (dmemB),
    .regfile_en  (regB),
    .phase       (phB),
    .running     (runB),
    .done        (doneB),
    .cycle_count (cntB)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s (%s) observed=%0h expected=%0h", tag, stepName, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic [1:0] ds);
    start   = st;
    stop    = sp;
    div_sel = ds;
  endtask

  task automatic modelReset();
    mActive = 1'b0;
    mDrain  = 1'b0;
    mDone   = 1'b0;
    mPos    = 0;
    mP      = 1;
    mCnt    = 0;
  endtask

  // Model tracks the clock's position within the current major cycle of 4*P clocks.
  task automatic modelStep();
    if (!mActive) begin
      mDone = 1'b0;
      if (start) begin
        mActive = 1'b1;
        mDrain  = 1'b0;
        mP      = 1 << div_sel;
        mPos    = 0;
        mCnt    = 0;
      end
    end else if (mPos == 4 * mP - 1) begin
      mCnt++;
      mPos = 0;
      if (mDrain || stop) begin
        mActive = 1'b0;
        mDone   = 1'b1;
      end else begin
        mDone = 1'b0;
        mP    = 1 << div_sel;
      end
    end else begin
      mDone = 1'b0;
      mPos++;
      if (stop) mDrain = 1'b1;
    end
  endtask

  task automatic checkOutput();
    logic [3:0] expEn;
    logic [1:0] expPh;
    expEn = 4'b0;
    expPh = 2'd0;
    if (mActive) begin
      expPh = 2'(mPos / mP);
      if (mPos % mP == mP - 1) expEn[mPos / mP] = 1'b1;
    end
    checkValue("A_enables", {28'b0, regA, dmemA, procA, imemA}, {28'b0, expEn});
    checkValue("A_phase",   {30'b0, phA},   {30'b0, expPh});
    checkValue("A_running", {31'b0, runA},  {31'b0, mActive});
    checkValue("A_done",    {31'b0, doneA}, {31'b0, mDone});
    checkValue("A_count",   {16'b0, cntA},  32'(mCnt % 65536));
    checkValue("B_enables", {28'b0, regB, dmemB, procB, imemB}, {28'b0, expEn});
    checkValue("B_phase",   {30'b0, phB},   {30'b0, expPh});
    checkValue("B_running", {31'b0, runB},  {31'b0, mActive});
    checkValue("B_done",    {31'b0, doneB}, {31'b0, mDone});
    checkValue("B_count",   {28'b0, cntB},  32'(mCnt % 16));
  endtask

  task automatic clearAcc();
    accEn   = 0;
    accReg  = 0;
    accDone = 0;
    accRun  = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep();
    #1;
    checkOutput();
    accEn   += int'(imemA) + int'(procA) + int'(dmemA) + int'(regA);
    accReg  += int'(regA);
    accDone += int'(doneA);
    accRun  += int'(runA);
  endtask

  task automatic runUntilIdle(input int budget);
    int n;
    n = 0;
    while ((mActive || mDone) && n < budget) begin
      tick();
      n++;
    end
    checkValue("idle_reached", {31'b0, runA}, 32'd0);
  endtask

  initial begin
    int idx, firstReg, secondReg;
    logic st, sp;
    logic [1:0] ds;

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0);
    modelReset();
    clearAcc();
    #2;
    stepName = "reset";
    checkOutput();
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();

    // div_sel=0, free running: enables back to back, count 3 after 12 clocks
    stepName = "div0_free";
    applyStimulus(1'b1, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0);
    repeat (12) tick();
    checkValue("div0_count3", {16'b0, cntA}, 32'd3);
    applyStimulus(1'b0, 1'b1, 2'd0);
    runUntilIdle(20);

    // P=4, stop in phase 1 drains the rest of the cycle
    stepName = "drain_p4";
    applyStimulus(1'b1, 1'b0, 2'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd2);
    repeat (4) tick();
    checkValue("p4_phase1", {30'b0, phA}, 32'd1);
    clearAcc();
    applyStimulus(1'b0, 1'b1, 2'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd2);
    runUntilIdle(40);
    checkValue("p4_reg_pulses", 32'(accReg), 32'd1);
    checkValue("p4_done_pulses", 32'(accDone), 32'd1);
    checkValue("p4_count", {16'b0, cntA}, 32'd1);

    // div_sel change mid-cycle only takes effect at the next boundary
    stepName = "psel_change";
    applyStimulus(1'b1, 1'b0, 2'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd1);
    idx = 1;
    firstReg = 0;
    secondReg = 0;
    for (int i = 0; i < 41; i++) begin
      if (idx == 3) applyStimulus(1'b0, 1'b0, 2'd3);
      tick();
      idx++;
      if (regA) begin
        if (firstReg == 0) firstReg = idx;
        else if (secondReg == 0) secondReg = idx;
      end
    end
    checkValue("psel_first_reg", 32'(firstReg), 32'd8);
    checkValue("psel_second_reg", 32'(secondReg), 32'd40);
    applyStimulus(1'b0, 1'b1, 2'd3);
    runUntilIdle(80);

    // Reset during DRAIN aborts without done; restart begins at phase 0
    stepName = "reset_drain";
    applyStimulus(1'b1, 1'b0, 2'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd3);
    repeat (10) tick();
    applyStimulus(1'b0, 1'b1, 2'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd3);
    repeat (5) tick();
    checkValue("drain_running", {31'b0, runA}, 32'd1);
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput();
    clearAcc();
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    checkValue("reset_no_done", 32'(accDone), 32'd0);
    applyStimulus(1'b1, 1'b0, 2'd3);
    tick();
    checkValue("restart_phase0", {30'b0, phA}, 32'd0);
    checkValue("restart_running", {31'b0, runA}, 32'd1);
    applyStimulus(1'b0, 1'b1, 2'd3);
    runUntilIdle(40);

    // 17 major cycles: the 4-bit counter wraps through 15 to 0 and ends at 1
    stepName = "wrap4";
    applyStimulus(1'b1, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0);
    repeat (68) tick();
    checkValue("wrap4_count", {28'b0, cntB}, 32'd1);
    checkValue("wrap16_count", {16'b0, cntA}, 32'd17);
    applyStimulus(1'b0, 1'b1, 2'd0);
    runUntilIdle(10);

    // start and stop together from IDLE run exactly one major cycle
    stepName = "start_stop";
    applyStimulus(1'b0, 1'b0, 2'd0);
    tick();
    clearAcc();
    applyStimulus(1'b1, 1'b1, 2'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 2'd0);
    runUntilIdle(20);
    checkValue("ss_enable_pulses", 32'(accEn), 32'd4);
    checkValue("ss_running_clocks", 32'(accRun), 32'd4);
    checkValue("ss_done_pulses", 32'(accDone), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0);
    tick();

    stepName = "random";
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 29) == 0);
      ds = ($urandom_range(0, 7) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
      applyStimulus(st, sp, ds);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 2'd0);
    runUntilIdle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_phase_scheduler.md
CLOCK_PHASE_SCHEDULER -- requirements
Module: clock_phase_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the completed-major-cycle counter.
REQ-002 SHALL have port clock, input, 1: the single clock; all state advances on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: level request to begin sequencing, sampled in IDLE only.
REQ-005 SHALL have port stop, input, 1: level request to end sequencing after the current major cycle.
REQ-006 SHALL have port div_sel, input, 2: phase length select; phase length P = 1 << div_sel clocks (1, 2, 4 or 8).
REQ-007 SHALL have port imem_en, output, 1: one-clock pulse ending phase 0.
REQ-008 SHALL have port proc_en, output, 1: one-clock pulse ending phase 1.
REQ-009 SHALL have port dmem_en, output, 1: one-clock pulse ending phase 2.
REQ-010 SHALL have port regfile_en, output, 1: one-clock pulse ending phase 3.
REQ-011 SHALL have port phase, output, 2: current phase index, 0 to 3.
REQ-012 SHALL have port running, output, 1: high in RUN and DRAIN.
REQ-013 SHALL have port done, output, 1: one-clock pulse when DRAIN completes.
REQ-014 SHALL have port cycle_count, output, CNT_W: number of completed major cycles since the last start.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DRAIN.
REQ-016 IDLE SHALL go to RUN when start=1, and on that edge SHALL latch div_sel into p_sel, clear the sub-counter, set phase=0 and clear cycle_count.
REQ-017 In RUN and DRAIN, the sub-counter SHALL count 0 to P-1. At P-1 it SHALL wrap to 0 and phase SHALL increment modulo 4.
REQ-018 The enable for the current phase SHALL be 1 exactly in the clock where sub-counter = P-1; all other enables SHALL be 0 in that clock. All enables SHALL be 0 in IDLE.
REQ-019 A major cycle is 4*P clocks. Its last clock is phase=3 with sub-counter=P-1. On that clock cycle_count SHALL increment, wrapping at 2^CNT_W-1 to 0.
REQ-020 p_sel SHALL be re-latched from div_sel only at a major-cycle boundary. A div_sel change mid-cycle SHALL NOT affect the cycle in progress.
REQ-021 stop=1 in RUN SHALL move the FSM to DRAIN on the next edge, except on a major-cycle boundary clock, where the FSM SHALL move directly to IDLE and pulse done.
REQ-022 DRAIN SHALL finish the current major cycle with all enables still generated, then go to IDLE and pulse done in the clock following the final regfile_en.
REQ-023 In DRAIN, start and stop SHALL be ignored. A new start SHALL be honoured only once the FSM is back in IDLE.
REQ-024 If start=1 and stop=1 together in IDLE, the FSM SHALL go to RUN and then obey stop per REQ-021, so exactly one full major cycle is executed.
REQ-025 In IDLE, phase and the sub-counter SHALL hold 0, and cycle_count SHALL hold its last value.
REQ-026 done and the four enables SHALL be registered outputs, with no combinational path from any input to any of them.

Reset
REQ-027 reset=0 SHALL asynchronously force: state=IDLE, all enables=0, done=0, running=0, phase=0, sub-counter=0, p_sel=0, cycle_count=0.
REQ-028 Reset asserted mid-RUN or mid-DRAIN SHALL abort immediately with no done pulse. After release, the block SHALL wait for a fresh start.

Structure
REQ-029 The FSM state encoding, the phase index constants (PH_IMEM=0, PH_PROC=1, PH_DMEM=2, PH_REG=3) and the P decode function SHALL reside in a shared package, clock_phase_pkg.
REQ-030 The sub-counter and phase counter SHALL form one sub-module, phase_counter (inputs: enable, clear, p_sel; outputs: phase, last_tick, cycle_end). The FSM, enable decode and cycle_count SHALL live in the top module.

Verification
REQ-031 div_sel=0, start pulsed, stop never: imem_en, proc_en, dmem_en and regfile_en SHALL pulse on consecutive clocks, repeating every 4 clocks; cycle_count SHALL reach 3 after 12 clocks.
REQ-032 div_sel=2 (P=4), stop raised in phase 1: DRAIN SHALL complete phases 2 and 3, regfile_en SHALL pulse once more, done SHALL pulse 1 clock later, and cycle_count SHALL read 1.
REQ-033 div_sel changed from 1 to 3 mid-cycle: the current cycle SHALL stay 8 clocks, and the next cycle SHALL be 32 clocks.
REQ-034 Reset pulled low during DRAIN with div_sel=3: all outputs SHALL be 0 immediately with no done; start after release SHALL begin at phase 0.
REQ-035 CNT_W=4, run 17 major cycles: cycle_count SHALL wrap 15 to 0 and read 1 at the end.
REQ-036 start=1 and stop=1 together in IDLE with div_sel=0: exactly 4 enable pulses, then done; running SHALL be high for exactly 4 clocks.
